// File: rtl/uart_pkg.sv
`timescale 1ns/100ps
// Shared UART timing constants and the rounded baud divisor used by RX, TX and their benches.
// Keeping the divisor math here guarantees every block derives identical tick timing.
package uart_pkg;

    localparam int CLK_FREQ_HZ  = 50_000_000;
    localparam int DEFAULT_BAUD = 9600;
    localparam int OVERSAMPLE   = 16;

    // Round-to-nearest integer divide; a non-positive denominator yields 0 so callers can flag it.
    function automatic longint calc_divisor(input longint f_clk, input longint baud, input longint samp);
        longint den;
        den = baud * samp;
        if (den <= 0)
            return 0;
        return (f_clk + den / 2) / den;
    endfunction

    function automatic int calc_cnt_w(input longint divisor);
        if (divisor <= 2)
            return 1;
        return $clog2(divisor);
    endfunction

endpackage

// File: rtl/baud_rate_generator.sv
`timescale 1ns/100ps
// Free-running divider emitting a registered one-cycle o_tick every DIVISOR clocks (SAMPLING x baud).
// First tick lands DIVISOR edges after reset release; no backpressure, the tick is a plain strobe.
module baud_rate_generator
    import uart_pkg::*;
#(
    parameter real F_CLOCK  = 50E6,
    parameter int  BAUDRATE = DEFAULT_BAUD,
    parameter int  SAMPLING = OVERSAMPLE
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam longint F_INT   = longint'(F_CLOCK);
    localparam int     DIVISOR = int'(calc_divisor(F_INT, longint'(BAUDRATE), longint'(SAMPLING)));
    localparam int     CNT_W   = calc_cnt_w(longint'(DIVISOR));

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIVISOR - 1);

    // Achieved tick rate versus requested, for the 2% rounding-error limit.
    localparam longint ACTUAL = longint'(DIVISOR) * longint'(BAUDRATE) * longint'(SAMPLING);
    localparam longint DIFF   = (ACTUAL > F_INT) ? (ACTUAL - F_INT) : (F_INT - ACTUAL);

    if (F_INT <= 0 || BAUDRATE <= 0 || SAMPLING <= 0) begin : g_bad_param
        $fatal(1, "baud_rate_generator: F_CLOCK, BAUDRATE and SAMPLING must all be positive");
    end

    if (DIVISOR < 2) begin : g_bad_divisor
        $fatal(1, "baud_rate_generator: DIVISOR %0d is below 2", DIVISOR);
    end

    if (DIFF * 50 > F_INT) begin : g_bad_error
        $fatal(1, "baud_rate_generator: rounding error exceeds 2%% (DIVISOR %0d)", DIVISOR);
    end

    logic [CNT_W-1:0] cnt;

    // >= rather than == so an unreachable encoding still recovers on the next edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else if (cnt >= TERM) begin
            cnt    <= '0;
            o_tick <= 1'b1;
        end else begin
            cnt    <= cnt + CNT_W'(1);
            o_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_rate_generator.sv
`timescale 1ns/100ps
// Bench for baud_rate_generator: three instances (default, DIVISOR=4, DIVISOR=54) share clock and reset.
// Expected tick edges are queued per instance and matched against captured ticks.
module tb_baud_rate_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_a;
    logic tick_b;
    logic tick_c;

    int checks   = 0;
    int failures = 0;

    localparam int DIV [3] = '{326, 4, 54};

    int  exp_q [3][$];
    int  obs_q [3][$];
    time first_a_t;

    always #1 clk = ~clk;

    baud_rate_generator dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .o_tick  (tick_a)
    );

    baud_rate_generator #(.F_CLOCK(16), .BAUDRATE(1), .SAMPLING(4)) dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .o_tick  (tick_b)
    );

    baud_rate_generator #(.F_CLOCK(100E6), .BAUDRATE(115200), .SAMPLING(16)) dut_c (
        .i_clk   (clk),
        .i_reset (rst),
        .o_tick  (tick_c)
    );

    // Reference model: after release, instance k ticks on edges DIV[k], 2*DIV[k], ...
    task automatic push_exp(input int n_edges);
        for (int k = 0; k < 3; k++) begin
            for (int e = DIV[k]; e <= n_edges; e += DIV[k])
                exp_q[k].push_back(e);
        end
    endtask

    // Records the edge index (counted from the call) of every tick seen; called at a negedge.
    task automatic capture(input int n_edges);
        first_a_t = 0;
        for (int i = 1; i <= n_edges; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (tick_a === 1'b1) begin
                if (first_a_t == 0)
                    first_a_t = $time - 1;
                obs_q[0].push_back(i);
            end
            if (tick_b === 1'b1) obs_q[1].push_back(i);
            if (tick_c === 1'b1) obs_q[2].push_back(i);
        end
    endtask

    task automatic pulse_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({tick_c, tick_b, tick_a} !== 3'b000) begin
                failures++;
                $display("FAIL reset_tick cycle %0d: got %b want 000", c, {tick_c, tick_b, tick_a});
            end
            checks++;
            if (dut_a.cnt !== 0 || dut_b.cnt !== 0 || dut_c.cnt !== 0) begin
                failures++;
                $display("FAIL reset_cnt cycle %0d: got %0d/%0d/%0d want 0/0/0",
                         c, dut_a.cnt, dut_b.cnt, dut_c.cnt);
            end
        end
        checks++;
        if (dut_b.CNT_W !== 2) begin
            failures++;
            $display("FAIL small_cnt_w: got %0d want 2", dut_b.CNT_W);
        end
        checks++;
        if (dut_c.DIVISOR !== 54) begin
            failures++;
            $display("FAIL rounded_divisor: got %0d want 54", dut_c.DIVISOR);
        end
    endtask

    task automatic test_first_tick;
        rst = 1'b0;
        push_exp(330);
        capture(330);
        checks++;
        if (first_a_t !== 661) begin
            failures++;
            $display("FAIL first_tick_time: got %0t want 661", first_a_t);
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                int e;
                int o;
                e = exp_q[k].pop_front();
                checks++;
                if (obs_q[k].size() == 0) begin
                    failures++;
                    $display("FAIL first_tick inst%0d: no tick, want edge %0d", k, e);
                end else begin
                    o = obs_q[k].pop_front();
                    if (o !== e) begin
                        failures++;
                        $display("FAIL first_tick inst%0d: tick at edge %0d want %0d", k, o, e);
                    end
                end
            end
            checks++;
            if (obs_q[k].size() !== 0) begin
                failures++;
                $display("FAIL first_tick_extra inst%0d: %0d extra ticks want 0", k, obs_q[k].size());
            end
            obs_q[k].delete();
        end
    endtask

    task automatic test_steady_period;
        pulse_reset(2);
        push_exp(5000);
        capture(5000);
        checks++;
        if (obs_q[0].size() !== 15) begin
            failures++;
            $display("FAIL steady_count: got %0d ticks want 15", obs_q[0].size());
        end
        checks++;
        if (obs_q[1].size() !== 1250) begin
            failures++;
            $display("FAIL small_count: got %0d ticks want 1250", obs_q[1].size());
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                int e;
                int o;
                e = exp_q[k].pop_front();
                checks++;
                if (obs_q[k].size() == 0) begin
                    failures++;
                    $display("FAIL steady inst%0d: no tick, want edge %0d", k, e);
                end else begin
                    o = obs_q[k].pop_front();
                    if (o !== e) begin
                        failures++;
                        $display("FAIL steady inst%0d: tick at edge %0d want %0d", k, o, e);
                    end
                end
            end
            checks++;
            if (obs_q[k].size() !== 0) begin
                failures++;
                $display("FAIL steady_extra inst%0d: %0d extra ticks want 0", k, obs_q[k].size());
            end
            obs_q[k].delete();
        end
    endtask

    task automatic test_mid_reset;
        pulse_reset(2);
        push_exp(200);
        capture(200);
        checks++;
        if (dut_a.cnt !== 200) begin
            failures++;
            $display("FAIL mid_count: got %0d want 200", dut_a.cnt);
        end
        // Asynchronous assertion between edges must clear state without waiting for a clock.
        rst = 1'b1;
        #0.2;
        checks++;
        if (dut_a.cnt !== 0 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: got cnt=%0d tick=%b want cnt=0 tick=0", dut_a.cnt, tick_a);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_exp(330);
        capture(330);
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                int e;
                int o;
                e = exp_q[k].pop_front();
                checks++;
                if (obs_q[k].size() == 0) begin
                    failures++;
                    $display("FAIL mid_reset inst%0d: no tick, want edge %0d", k, e);
                end else begin
                    o = obs_q[k].pop_front();
                    if (o !== e) begin
                        failures++;
                        $display("FAIL mid_reset inst%0d: tick at edge %0d want %0d", k, o, e);
                    end
                end
            end
            checks++;
            if (obs_q[k].size() !== 0) begin
                failures++;
                $display("FAIL mid_reset_extra inst%0d: %0d extra ticks want 0", k, obs_q[k].size());
            end
            obs_q[k].delete();
        end
    endtask

    task automatic test_tick_cancel;
        pulse_reset(2);
        push_exp(326);
        capture(326);
        checks++;
        if (tick_a !== 1'b1) begin
            failures++;
            $display("FAIL cancel_pre: tick got %b want 1", tick_a);
        end
        rst = 1'b1;
        #0.2;
        checks++;
        if (tick_a !== 1'b0) begin
            failures++;
            $display("FAIL cancel_clear: tick got %b want 0", tick_a);
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                int e;
                int o;
                e = exp_q[k].pop_front();
                checks++;
                if (obs_q[k].size() == 0) begin
                    failures++;
                    $display("FAIL cancel inst%0d: no tick, want edge %0d", k, e);
                end else begin
                    o = obs_q[k].pop_front();
                    if (o !== e) begin
                        failures++;
                        $display("FAIL cancel inst%0d: tick at edge %0d want %0d", k, o, e);
                    end
                end
            end
            obs_q[k].delete();
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_steady_period();
        test_mid_reset();
        test_tick_cancel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
